// File: rtl/load_store_arbiter.sv
// load_store_arbiter
//   Shares one single-port memory among NUM_REQ requesters. A round-robin
//   arbiter picks one pending requester while idle. A WAIT/LOAD/LOAD_RSP/STORE
//   state machine then drives the memory port. The winner gets a registered
//   one-cycle ack, and loads also return their read data.
//
// Ports
//   clock_i      clock, rising edge
//   reset_i      synchronous active-high reset
//   req_i        per-requester access request
//   req_we_i     per-requester 1=store, 0=load
//   req_addr_i   packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata_i  packed write data, requester i at [i*DATA_W +: DATA_W]
//   ack_o        one-hot one-cycle completion pulse
//   rsp_rdata_o  load data, valid while ack_o is high, held otherwise
//   mem_en_o     memory access request
//   mem_we_o     memory write enable
//   mem_addr_o   memory address
//   mem_wdata_o  memory write data
//   mem_ready_i  memory accepts the access when mem_en_o && mem_ready_i
//   mem_rdata_i  memory read data, valid one cycle after load acceptance
//   busy_o       state machine is not in WAIT
//   state_o      WAIT=0, LOAD=1, LOAD_RSP=2, STORE=3
module load_store_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o,
  output logic [1:0]                state_o
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_LOAD_RSP = 2'd2,
    ST_STORE    = 2'd3
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [NUM_REQ-1:0]  elig_d;
  logic                grant_vld_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [ID_W-1:0]     ptr_d;
  logic                grant_we_d;
  logic [ADDR_W-1:0]   grant_addr_d;
  logic [DATA_W-1:0]   grant_wdata_d;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Unpack the per-requester address and data buses.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
  end

  // Round-robin winner selection, searching upward from ptr_q with wrap.
  always_comb begin
    // The requester being acked this cycle is still holding req and
    // must not be granted again.
    elig_d      = req_i & ~ack_q;
    grant_vld_d = 1'b0;
    grant_id_d  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld_d && elig_d[idx]) begin
        grant_vld_d = 1'b1;
        grant_id_d  = idx;
      end else begin
        grant_vld_d = grant_vld_d;
      end
    end
    ptr_d         = ID_W'((int'(grant_id_d) + 1) % NUM_REQ);
    grant_we_d    = req_we_i[grant_id_d];
    grant_addr_d  = addr_arr[grant_id_d];
    grant_wdata_d = wdata_arr[grant_id_d];
  end

  // Access sequencing state machine with registered memory and ack outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_WAIT;
      ptr_q       <= '0;
      id_q        <= '0;
      ack_q       <= '0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_WAIT: begin
          if (grant_vld_d) begin
            // Requester inputs are captured here and ignored afterwards.
            id_q        <= grant_id_d;
            ptr_q       <= ptr_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_we_d;
            mem_addr_q  <= grant_addr_d;
            mem_wdata_q <= grant_wdata_d;
            state_q     <= grant_we_d ? ST_STORE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (mem_ready_i) begin
            mem_en_q <= 1'b0;
            state_q  <= ST_LOAD_RSP;
          end
        end
        ST_LOAD_RSP: begin
          rsp_rdata_q <= mem_rdata_i;
          ack_q       <= onehot(id_q);
          state_q     <= ST_WAIT;
        end
        ST_STORE: begin
          if (mem_ready_i) begin
            mem_en_q <= 1'b0;
            ack_q    <= onehot(id_q);
            state_q  <= ST_WAIT;
          end
        end
        default: begin
          mem_en_q <= 1'b0;
          state_q  <= ST_WAIT;
        end
      endcase
    end
  end

  assign ack_o       = ack_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_WAIT);
  assign state_o     = state_q;

endmodule

// File: tb/tb_load_store_arbiter.sv
module tb_load_store_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  ack;
  logic [15:0] rsp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [1:0]  state;

  int n_vec;
  int n_bad;
  int step;

  logic [15:0] mem_m [256];

  load_store_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_i       (req),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .ack_o       (ack),
    .rsp_rdata_o (rsp_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .state_o     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory: stores write, loads return data one cycle later.
  always @(posedge clock) begin
    if (mem_en && mem_ready) begin
      if (mem_we) mem_m[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_m[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        rdy;
    logic [3:0]  ack;
    logic [15:0] rdata;
    logic        en;
    logic        mwe;
    logic [7:0]  maddr;
    logic [15:0] mwdata;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] we,
                              input logic [31:0] ad, input logic [63:0] wd, input logic rdy,
                              input logic [3:0] ak, input logic [15:0] rd, input logic en,
                              input logic mwe, input logic [7:0] ma, input logic [15:0] mw,
                              input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.req = rq; v.we = we; v.addr = ad; v.wdata = wd; v.rdy = rdy;
    v.ack = ak; v.rdata = rd; v.en = en; v.mwe = mwe; v.maddr = ma; v.mwdata = mw; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, step, act, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] A2 = 32'h0000_1000;
  localparam logic [63:0] W2 = 64'h0000_0000_BEEF_0000;
  localparam logic [31:0] A3 = 32'h0010_0000;
  localparam logic [31:0] A5 = 32'h2200_0000;
  localparam logic [31:0] A1 = 32'h0000_0030;
  localparam logic [31:0] AR = 32'h4342_4140;
  localparam logic [63:0] W0 = 64'h0;

  initial begin
    n_vec = 0;
    n_bad = 0;
    step  = 0;
    for (int a = 0; a < 256; a++) mem_m[a] = 16'h5A00 | 16'(a);
    mem_rdata = 16'h0000;
    reset = 1'b1; req = 4'b0000; req_we = 4'b0000;
    req_addr = 32'h0; req_wdata = 64'h0; mem_ready = 1'b1;

    //      rst  req      we       addr wdata rdy | ack     rdata     en    mwe   maddr   mwdata      st
    // store by requester 1 (ack kept high through the ack cycle), then load by requester 2
    vq.push_back(mk(1'b0, 4'b0010, 4'b0010, A2, W2, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0010, 4'b0010, A2, W2, 1'b1, 4'b0000, 16'h0000, 1'b1, 1'b1, 8'h10, 16'hBEEF, 2'd3));
    vq.push_back(mk(1'b0, 4'b0010, 4'b0010, A2, W2, 1'b1, 4'b0010, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0100, 4'b0000, A3, W0, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0100, 4'b0000, A3, W0, 1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b0100, 4'b0000, A3, W0, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b0100, 4'b0000, A3, W0, 1'b1, 4'b0100, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, A3, W0, 1'b1, 4'b0000, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    // backpressure: requester 3 load, mem_ready low for three LOAD cycles
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b0, 4'b0000, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b0, 4'b0000, 16'hBEEF, 1'b1, 1'b0, 8'h22, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b0, 4'b0000, 16'hBEEF, 1'b1, 1'b0, 8'h22, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b0, 4'b0000, 16'hBEEF, 1'b1, 1'b0, 8'h22, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b1, 4'b0000, 16'hBEEF, 1'b1, 1'b0, 8'h22, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b1, 4'b0000, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b1000, 4'b0000, A5, W0, 1'b1, 4'b1000, 16'h5A22, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, A5, W0, 1'b1, 4'b0000, 16'h5A22, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    // reset for two cycles while stalled in LOAD (grant to 0 moves ptr to 1)
    vq.push_back(mk(1'b0, 4'b0001, 4'b0000, A1, W0, 1'b0, 4'b0000, 16'h5A22, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b1, 4'b0001, 4'b0000, A1, W0, 1'b0, 4'b0000, 16'h5A22, 1'b1, 1'b0, 8'h30, 16'h0000, 2'd1));
    vq.push_back(mk(1'b1, 4'b0000, 4'b0000, A1, W0, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    // round robin with all four loading; reset returned ptr to 0
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h0000, 1'b1, 1'b0, 8'h40, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0001, 16'h5A40, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A40, 1'b1, 1'b0, 8'h41, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A40, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0010, 16'h5A41, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A41, 1'b1, 1'b0, 8'h42, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A41, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0100, 16'h5A42, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A42, 1'b1, 1'b0, 8'h43, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A42, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b1000, 16'h5A43, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A43, 1'b1, 1'b0, 8'h40, 16'h0000, 2'd1));
    vq.push_back(mk(1'b0, 4'b1111, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A43, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd2));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, AR, W0, 1'b1, 4'b0001, 16'h5A40, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));
    vq.push_back(mk(1'b0, 4'b0000, 4'b0000, AR, W0, 1'b1, 4'b0000, 16'h5A40, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0));

    // Initial reset: every output must be zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_mem_en", 64'(mem_en), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);

    // Table: each row is the inputs and expected outputs of one cycle.
    foreach (vq[i]) begin
      @(negedge clock);
      step = i;
      reset = vq[i].rst; req = vq[i].req; req_we = vq[i].we;
      req_addr = vq[i].addr; req_wdata = vq[i].wdata; mem_ready = vq[i].rdy;
      n_vec++;
      chk("state", 64'(state), 64'(vq[i].st));
      chk("busy", 64'(busy), 64'(vq[i].st != 2'd0));
      chk("ack", 64'(ack), 64'(vq[i].ack));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(vq[i].rdata));
      chk("mem_en", 64'(mem_en), 64'(vq[i].en));
      if (vq[i].en) begin
        chk("mem_we", 64'(mem_we), 64'(vq[i].mwe));
        chk("mem_addr", 64'(mem_addr), 64'(vq[i].maddr));
        if (vq[i].mwe) chk("mem_wdata", 64'(mem_wdata), 64'(vq[i].mwdata));
      end
    end

    // Masking: requester 0 keeps req high through its ack; each new grant
    // waits one WAIT cycle, so acks land every 4 cycles with no duplicates.
    for (int k = 0; k < 12; k++) begin
      logic [1:0] exp_st;
      logic       exp_ack;
      @(negedge clock);
      step = 100 + k;
      reset = 1'b0; req = 4'b0001; req_we = 4'b0000;
      req_addr = 32'h0000_0050; req_wdata = 64'h0; mem_ready = 1'b1;
      exp_ack = ((k % 4) == 3);
      case (k % 4)
        0: exp_st = 2'd0;
        1: exp_st = 2'd1;
        2: exp_st = 2'd2;
        default: exp_st = 2'd0;
      endcase
      n_vec++;
      chk("mask_state", 64'(state), 64'(exp_st));
      chk("mask_ack", 64'(ack), exp_ack ? 64'd1 : 64'd0);
      if (exp_ack) chk("mask_rdata", 64'(rsp_rdata), 64'h5A50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
